fifo_drain_ctrl: RTL
====================

// Module: fifo_drain_ctrl
// PURPOSE
// - Read-side sequencer for the async FIFO, in the read (destination) clock domain.
// - Pops one word whenever the FIFO is non-empty and enabled, and hands it to a serial consumer (e.g. UART TX) over a pulse/busy handshake.
// - Enforces a programmable inter-word gap, retries a strobe the consumer ignores, and counts words delivered.
// PARAMETERS
// - DATA_WIDTH  8   width of FIFO read data and TX data
// - GAP_WIDTH   8   width of GAP_CFG and of the gap counter
// - ACK_TO      16  cycles to wait for TX_BUSY rise before re-strobing (>=2)
// - CNT_WIDTH   16  width of WORD_CNT
// PORTS
// - CLK       in   1           read-domain clock
// - RST       in   1           asynchronous active-low reset
// - EN        in   1           drain enable; sampled only in IDLE
// - GAP_CFG   in   GAP_WIDTH   idle cycles inserted after each word (0 = none)
// - EMPTY     in   1           FIFO empty flag (read domain)
// - RD_DATA   in   DATA_WIDTH  FIFO read data, valid while EMPTY=0
// - R_INC     out  1           FIFO pop strobe, one cycle per word
// - TX_DATA   out  DATA_WIDTH  word presented to consumer, held stable from strobe until BUSY falls
// - TX_VALID  out  1           one-cycle data-valid strobe to consumer
// - TX_BUSY   in   1           consumer busy; high while word is transmitted
// - WORD_CNT  out  CNT_WIDTH   words completed since reset, wraps modulo 2^CNT_WIDTH
// - RETRY_ERR out  1           sticky; set on first ACK timeout, cleared only by reset
// BEHAVIOUR
// - All outputs registered. Reset: state IDLE, R_INC=0, TX_VALID=0, TX_DATA=0, WORD_CNT=0, RETRY_ERR=0, counters 0.
// - FSM states: IDLE, FETCH, STROBE, WAIT_BUSY, WAIT_DONE, GAP.
// - IDLE: if EN=1 and EMPTY=0 -> FETCH; else stay.
// - FETCH (1 cycle): R_INC=1; TX_DATA <= RD_DATA at exit edge (pre-increment word) -> STROBE.
// - STROBE (1 cycle): TX_VALID=1; timeout counter loaded with ACK_TO -> WAIT_BUSY.
// - WAIT_BUSY: TX_BUSY=1 -> WAIT_DONE; counter reaches 0 with no BUSY -> RETRY_ERR<=1, back to STROBE (same TX_DATA, no new pop).
// - WAIT_DONE: TX_BUSY=0 -> WORD_CNT+1; GAP_CFG=0 -> IDLE, else load gap counter with GAP_CFG -> GAP.
// - GAP: decrement each cycle; exit to IDLE on the cycle the counter is 1 (exactly GAP_CFG cycles in GAP).
// - GAP_CFG sampled once on entry to GAP; changes mid-gap take effect on next word.
// - Latency: EMPTY falls with EN=1 in IDLE -> R_INC next cycle -> TX_VALID the cycle after (2 cycles).
// - Min per-word period with instant BUSY response and GAP_CFG=0: FETCH+STROBE+>=1 WAIT_BUSY+>=1 WAIT_DONE.
// - Exactly one R_INC per delivered word; never asserted while EMPTY=1 (EMPTY checked in IDLE; only this block pops).
// - EN deassert mid-word: current word completes through GAP; then holds in IDLE.
// - TX_BUSY already high in STROBE cycle: treated as acknowledgement on the first WAIT_BUSY cycle.
// - Reset mid-word: popped word is discarded, not re-read; FSM to IDLE.
// - WORD_CNT wraps all-ones -> 0 without flag.
// STRUCTURE
// - Package fifo_drain_pkg: state enum (6 states, binary encoding), ACK_TO default, state-name constants for bench.
// - Sub-module fifo_drain_timer: loadable down counter (load, value, dec, zero flag), instantiated twice (ACK timeout, GAP) or shared once since they never overlap -- one shared instance.
// - Top: FSM, TX_DATA register, WORD_CNT, RETRY_ERR.
// TESTING
// - Single word: EN=1, FIFO holds 0xA5, consumer raises BUSY 1 cycle after strobe for 10 cycles -> one R_INC, TX_DATA=0xA5, one TX_VALID, WORD_CNT=1.
// - Burst of 4 (0x01..0x04), GAP_CFG=3 -> 4 R_INC pulses, TX_DATA sequence 0x01..0x04, exactly 3 GAP cycles between BUSY fall and next R_INC+... -> WORD_CNT=4, EMPTY ends 1, FSM IDLE.
// - Ignored strobe: BUSY held 0 for ACK_TO+5 cycles then responds -> second TX_VALID ACK_TO+1 cycles after the first, no extra R_INC, RETRY_ERR=1, WORD_CNT=1.
// - EN dropped during WAIT_DONE with 2 words queued -> current word finishes, WORD_CNT+1, no further R_INC while EN=0; EN re-raised -> next word drained.
// - Reset asserted in WAIT_BUSY -> all outputs 0 asynchronously, FSM IDLE; after release next queued word popped, WORD_CNT counts from 0.
// - WORD_CNT wrap with CNT_WIDTH=4: 17 words -> WORD_CNT=1, no other side effects.

Source files
------------

// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the async-FIFO read-side drain sequencer.
package fifo_drain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_STROBE    = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_GAP       = 3'd5
    } drain_state_e;

    localparam int NUM_STATES     = 6;
    localparam int ACK_TO_DEFAULT = 16;

    // The shared timer must hold both the ACK timeout and the largest gap value.
    function automatic int timer_width(input int ack_to, input int gap_width);
        int w;
        w = $clog2(ack_to + 1);
        return (w > gap_width) ? w : gap_width;
    endfunction

endpackage

// File: rtl/fifo_drain_timer.sv
// Loadable down counter; saturates at zero, load takes priority over decrement.
module fifo_drain_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero,
    output logic             last
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
    assign last = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Read-domain drain sequencer: pops the async FIFO one word at a time and hands
// each word to a serial consumer over a strobe/busy handshake with retry and gap.
module fifo_drain_ctrl
    import fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int GAP_WIDTH  = 8,
    parameter int ACK_TO     = ACK_TO_DEFAULT,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic [GAP_WIDTH-1:0]  GAP_CFG,
    input  logic                  EMPTY,
    input  logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  R_INC,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  TX_VALID,
    input  logic                  TX_BUSY,
    output logic [CNT_WIDTH-1:0]  WORD_CNT,
    output logic                  RETRY_ERR
);

    localparam int               TMR_W    = timer_width(ACK_TO, GAP_WIDTH);
    localparam logic [TMR_W-1:0] ACK_LOAD = TMR_W'(ACK_TO);

    drain_state_e          state_q, state_d;
    logic                  r_inc_q, r_inc_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
    logic                  retry_err_q, retry_err_d;

    logic                  tmr_load;
    logic [TMR_W-1:0]      tmr_val;
    logic                  tmr_dec;
    logic                  tmr_zero;
    logic                  tmr_last;

    // The ACK timeout and the inter-word gap never overlap, so one timer serves both.
    fifo_drain_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk      (CLK),
        .rst_n    (RST),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero),
        .last     (tmr_last)
    );

    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        word_cnt_d  = word_cnt_q;
        retry_err_d = retry_err_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        tmr_dec     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (EN && !EMPTY) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // RD_DATA still shows the popped word until this edge advances the pointer.
                tx_data_d = RD_DATA;
                state_d   = ST_STROBE;
            end
            ST_STROBE: begin
                tmr_load = 1'b1;
                tmr_val  = ACK_LOAD;
                state_d  = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (TX_BUSY) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    tmr_dec = 1'b1;
                    if (tmr_last || tmr_zero) begin
                        retry_err_d = 1'b1;
                        state_d     = ST_STROBE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (!TX_BUSY) begin
                    word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
                    if (GAP_CFG == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(GAP_CFG);
                        state_d  = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                tmr_dec = 1'b1;
                if (tmr_last || tmr_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        r_inc_d    = (state_d == ST_FETCH);
        tx_valid_d = (state_d == ST_STROBE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            r_inc_q     <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            word_cnt_q  <= '0;
            retry_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_inc_q     <= r_inc_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            word_cnt_q  <= word_cnt_d;
            retry_err_q <= retry_err_d;
        end
    end

    assign R_INC     = r_inc_q;
    assign TX_VALID  = tx_valid_q;
    assign TX_DATA   = tx_data_q;
    assign WORD_CNT  = word_cnt_q;
    assign RETRY_ERR = retry_err_q;

endmodule
